pilha: RTL and testbench
========================

PILHA -- requirements
Module: pilha

Interface
REQ-001 Parameter WIDTH, default 8, bit width of each stored word.
REQ-002 Parameter DEPTH, default 8, number of entries; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 data_in  input  WIDTH  word offered by the upstream deserializer.
REQ-006 data_ready_in  input  1  high while data_in holds a valid word awaiting acknowledge.
REQ-007 ack_out  output  1  one-cycle pulse confirming data_in was pushed.
REQ-008 pop_in  input  1  request to remove the top entry this cycle.
REQ-009 data_out  output  WIDTH  word removed by the last accepted pop.
REQ-010 data_valid_out  output  1  one-cycle pulse; data_out is valid this cycle.
REQ-011 full  output  1  count == DEPTH.
REQ-012 empty  output  1  count == 0.
REQ-013 count  output  $clog2(DEPTH)+1  number of stored entries.

Function
REQ-014 LIFO storage of DEPTH x WIDTH registers; stack pointer equals count; top entry at index count-1.
REQ-015 Push FSM states: IDLE, ACK, WAIT_LOW.
REQ-016 IDLE: if data_ready_in=1 and a push slot is available, write data_in at index count; go to ACK.
REQ-017 ACK: ack_out=1 for exactly this cycle; go to WAIT_LOW.
REQ-018 WAIT_LOW: no further push; return to IDLE when data_ready_in=0, so one offered word is never pushed twice.
REQ-019 A push slot is available when full=0, or when full=1 and an accepted pop occurs in the same cycle.
REQ-020 Full and no pop: FSM stays in IDLE, ack_out stays 0, word held off until space exists.
REQ-021 Pop accepted when pop_in=1 and empty=0: data_out <= top entry and data_valid_out=1 on the next cycle.
REQ-022 Pop latency: one cycle from pop_in sample to data_valid_out.
REQ-023 Push and pop accepted in the same cycle: data_out receives the old top, the new word overwrites that position, count unchanged.
REQ-024 Push and pop in the same cycle while empty: push performed, pop ignored, no data_valid_out.
REQ-025 pop_in while empty (no push): ignored; count, data_out unchanged.
REQ-026 count SHALL never exceed DEPTH nor go below 0; no wrap-around.
REQ-027 data_out holds its last value between pops.
REQ-028 full, empty and count are registered and reflect the state after the last edge.

Reset
REQ-029 reset=0 asynchronously forces: FSM=IDLE, count=0, empty=1, full=0, ack_out=0, data_valid_out=0, data_out=0.
REQ-030 Storage contents need not be cleared on reset.
REQ-031 Reset asserted mid-handshake aborts it; a word offered before reset and still held after release is pushed once.

Configuration
REQ-032 Macro PILHA_UNDERFLOW_ERR_EN, when defined, adds output err_out (1 bit) and input clear_err_in (1 bit).
REQ-033 With the macro: err_out set on any pop_in=1 while empty=1 with no push accepted that cycle; sticky until clear_err_in=1 or reset; set has priority over clear in the same cycle.
REQ-034 Without the macro: those ports are absent and underflow pops are silently ignored.

Verification
REQ-035 Reset, push 0xA5 (data_ready_in held until ack) -> one ack_out pulse, count=1, empty=0, single push only.
REQ-036 Push 0x11,0x22,0x33 then three pops -> data_out 0x33,0x22,0x11 each with one data_valid_out pulse, empty=1.
REQ-037 Fill DEPTH words, offer 0x77 -> no ack_out, full=1; then pop -> same cycle 0x77 pushed, old top on data_out, count=DEPTH.
REQ-038 Empty, pop_in=1 -> no data_valid_out, count=0; with PILHA_UNDERFLOW_ERR_EN err_out=1 until clear_err_in.
REQ-039 Count=3, push 0x5C with pop same cycle -> data_out=old top, count=3, next pop returns 0x5C.
REQ-040 Assert reset during ACK with count=4 -> all outputs at reset values, count=0, ack_out=0 immediately.

Source files
------------

// File: rtl/pilha.sv
// LIFO stack with a ready/ack push handshake and a one-cycle-latency pop.
// Optional macro PILHA_UNDERFLOW_ERR_EN adds a sticky underflow flag (err_out/clear_err_in).
module pilha #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     data_ready_in,
    output logic                     ack_out,
    input  logic                     pop_in,
    output logic [WIDTH-1:0]         data_out,
    output logic                     data_valid_out,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
`ifdef PILHA_UNDERFLOW_ERR_EN
    ,
    output logic                     err_out,
    input  logic                     clear_err_in
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count_d;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_idx;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok  = pop_in && !empty;
    assign top_idx = count[AW-1:0] - AW'(1);
    // A simultaneous pop frees the top slot, so the new word lands where the old top was.
    assign wr_idx  = pop_ok ? top_idx : count[AW-1:0];

    always_comb begin
        state_d = state_q;
        push_ok = 1'b0;
        ack_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_ready_in && (!full || pop_ok)) begin
                    push_ok = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                ack_out = 1'b1;
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!data_ready_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count + CW'(1);
            2'b01:   count_d = count - CW'(1);
            default: count_d = count;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            count          <= '0;
            empty          <= 1'b1;
            full           <= 1'b0;
            data_out       <= '0;
            data_valid_out <= 1'b0;
        end else begin
            state_q        <= state_d;
            count          <= count_d;
            empty          <= (count_d == '0);
            full           <= (count_d == DEPTH_C);
            data_valid_out <= pop_ok;
            if (pop_ok) begin
                data_out <= mem[top_idx];
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_idx] <= data_in;
        end
    end

`ifdef PILHA_UNDERFLOW_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (pop_in && empty && !push_ok) begin
            err_q <= 1'b1;
        end else if (clear_err_in) begin
            err_q <= 1'b0;
        end
    end

    assign err_out = err_q;
`endif

endmodule

// File: tb/tb_pilha.sv
// Directed self-checking bench for pilha (WIDTH=8, DEPTH=8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_pilha;

    logic       clk;
    logic       reset;
    logic [7:0] data_in;
    logic       data_ready_in;
    logic       ack_out;
    logic       pop_in;
    logic [7:0] data_out;
    logic       data_valid_out;
    logic       full;
    logic       empty;
    logic [3:0] count;
`ifdef PILHA_UNDERFLOW_ERR_EN
    logic       err_out;
    logic       clear_err_in;
`endif

    int check_count;
    int pass_count;

    pilha #(.WIDTH(8), .DEPTH(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .data_in        (data_in),
        .data_ready_in  (data_ready_in),
        .ack_out        (ack_out),
        .pop_in         (pop_in),
        .data_out       (data_out),
        .data_valid_out (data_valid_out),
        .full           (full),
        .empty          (empty),
        .count          (count)
`ifdef PILHA_UNDERFLOW_ERR_EN
        ,
        .err_out        (err_out),
        .clear_err_in   (clear_err_in)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ready, input logic [7:0] value, input logic pop);
        data_ready_in = ready;
        data_in       = value;
        pop_in        = pop;
    endtask

    task automatic pushWord(input logic [7:0] value);
        bit got;
        got = 1'b0;
        applyStimulus(1'b1, value, 1'b0);
        for (int n = 0; n < 10 && !got; n++) begin
            tick();
            if (ack_out) got = 1'b1;
        end
        checkOutput("push_ack", {31'b0, got}, 32'd1);
        applyStimulus(1'b0, value, 1'b0);
        tick();
        tick();
    endtask

    task automatic popWord(input logic [7:0] expected, input logic [3:0] exp_count);
        applyStimulus(1'b0, 8'h00, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("pop_valid", {31'b0, data_valid_out}, 32'd1);
        checkOutput("pop_data", {24'b0, data_out}, {24'b0, expected});
        checkOutput("pop_count", {28'b0, count}, {28'b0, exp_count});
        tick();
        checkOutput("pop_valid_pulse", {31'b0, data_valid_out}, 32'd0);
        checkOutput("pop_data_hold", {24'b0, data_out}, {24'b0, expected});
    endtask

    initial begin
        int acks;
        check_count = 0;
        pass_count  = 0;
        reset = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0);
`ifdef PILHA_UNDERFLOW_ERR_EN
        clear_err_in = 1'b0;
`endif
        tick();
        tick();
        checkOutput("rst_count", {28'b0, count}, 32'd0);
        checkOutput("rst_empty", {31'b0, empty}, 32'd1);
        checkOutput("rst_full", {31'b0, full}, 32'd0);
        checkOutput("rst_ack", {31'b0, ack_out}, 32'd0);
        checkOutput("rst_valid", {31'b0, data_valid_out}, 32'd0);
        checkOutput("rst_data", {24'b0, data_out}, 32'd0);
        reset = 1'b1;

        // Single push with ready held well past the ack.
        applyStimulus(1'b1, 8'hA5, 1'b0);
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ack_out) acks++;
        end
        checkOutput("a5_acks", acks, 32'd1);
        checkOutput("a5_count", {28'b0, count}, 32'd1);
        checkOutput("a5_empty", {31'b0, empty}, 32'd0);
        applyStimulus(1'b0, 8'hA5, 1'b0);
        tick();
        popWord(8'hA5, 4'd0);
        checkOutput("a5_empty_after", {31'b0, empty}, 32'd1);

        // LIFO order.
        pushWord(8'h11);
        pushWord(8'h22);
        pushWord(8'h33);
        checkOutput("three_count", {28'b0, count}, 32'd3);
        popWord(8'h33, 4'd2);
        popWord(8'h22, 4'd1);
        popWord(8'h11, 4'd0);
        checkOutput("three_empty", {31'b0, empty}, 32'd1);

        // Underflow pop is ignored.
        applyStimulus(1'b0, 8'h00, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("uf_valid", {31'b0, data_valid_out}, 32'd0);
        checkOutput("uf_count", {28'b0, count}, 32'd0);
        checkOutput("uf_data", {24'b0, data_out}, 32'h11);
`ifdef PILHA_UNDERFLOW_ERR_EN
        checkOutput("uf_err_set", {31'b0, err_out}, 32'd1);
        tick();
        checkOutput("uf_err_sticky", {31'b0, err_out}, 32'd1);
        clear_err_in = 1'b1;
        tick();
        clear_err_in = 1'b0;
        checkOutput("uf_err_clear", {31'b0, err_out}, 32'd0);
`endif

        // Push and pop together while empty: push wins, no pop.
        applyStimulus(1'b1, 8'h3C, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h3C, 1'b0);
        checkOutput("ep_ack", {31'b0, ack_out}, 32'd1);
        checkOutput("ep_valid", {31'b0, data_valid_out}, 32'd0);
        checkOutput("ep_count", {28'b0, count}, 32'd1);
`ifdef PILHA_UNDERFLOW_ERR_EN
        checkOutput("ep_err", {31'b0, err_out}, 32'd0);
`endif
        tick();
        tick();
        popWord(8'h3C, 4'd0);

        // Fill, then offer a word while full.
        for (int i = 1; i <= 8; i++) pushWord(8'(i));
        checkOutput("fill_full", {31'b0, full}, 32'd1);
        checkOutput("fill_count", {28'b0, count}, 32'd8);
        applyStimulus(1'b1, 8'h77, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("full_no_ack", {31'b0, ack_out}, 32'd0);
        end
        checkOutput("full_hold_count", {28'b0, count}, 32'd8);
        applyStimulus(1'b1, 8'h77, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h77, 1'b0);
        checkOutput("fullpp_ack", {31'b0, ack_out}, 32'd1);
        checkOutput("fullpp_valid", {31'b0, data_valid_out}, 32'd1);
        checkOutput("fullpp_data", {24'b0, data_out}, 32'h08);
        checkOutput("fullpp_count", {28'b0, count}, 32'd8);
        checkOutput("fullpp_full", {31'b0, full}, 32'd1);
        tick();
        tick();
        popWord(8'h77, 4'd7);
        popWord(8'h07, 4'd6);
        popWord(8'h06, 4'd5);
        popWord(8'h05, 4'd4);
        popWord(8'h04, 4'd3);

        // Simultaneous push and pop at count 3.
        applyStimulus(1'b1, 8'h5C, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h5C, 1'b0);
        checkOutput("pp_ack", {31'b0, ack_out}, 32'd1);
        checkOutput("pp_valid", {31'b0, data_valid_out}, 32'd1);
        checkOutput("pp_data", {24'b0, data_out}, 32'h03);
        checkOutput("pp_count", {28'b0, count}, 32'd3);
        tick();
        tick();
        popWord(8'h5C, 4'd2);

        // Reset while in ACK with count 4, word still offered afterwards.
        pushWord(8'hA1);
        applyStimulus(1'b1, 8'hB2, 1'b0);
        tick();
        checkOutput("mid_ack", {31'b0, ack_out}, 32'd1);
        checkOutput("mid_count", {28'b0, count}, 32'd4);
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_ack", {31'b0, ack_out}, 32'd0);
        checkOutput("mid_rst_count", {28'b0, count}, 32'd0);
        checkOutput("mid_rst_empty", {31'b0, empty}, 32'd1);
        checkOutput("mid_rst_full", {31'b0, full}, 32'd0);
        checkOutput("mid_rst_valid", {31'b0, data_valid_out}, 32'd0);
        checkOutput("mid_rst_data", {24'b0, data_out}, 32'd0);
        #2;
        reset = 1'b1;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ack_out) acks++;
        end
        checkOutput("post_rst_acks", acks, 32'd1);
        checkOutput("post_rst_count", {28'b0, count}, 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        tick();
        popWord(8'hB2, 4'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
